// File: rtl/and_gate.sv
// and_gate: three-input bitwise AND with an optional PIPE-stage output register chain and reduction flags
module and_gate #(
  parameter int WIDTH = 1,
  parameter int PIPE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] p,
  output logic             p_all,
  output logic             p_any
);
  if (WIDTH < 1 || PIPE < 0 || PIPE > 8) begin : g_bad
    $error("and_gate: WIDTH must be >=1 and PIPE must be 0..8");
  end
  if (PIPE == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign p = x & y & z;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_d [PIPE];
    logic [WIDTH-1:0] pipe_q [PIPE];
    always_comb begin
      pipe_d[0] = x & y & z;
      for (int k = 1; k < PIPE; k++) pipe_d[k] = pipe_q[k-1];
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) pipe_q <= '{default: '0};
      else pipe_q <= pipe_d;
    assign p = pipe_q[PIPE-1];
  end
  assign p_all = &p;
  assign p_any = |p;
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed and reference-model checks of and_gate across four PIPE/WIDTH configurations
module tb_and_gate;
  logic clk = 0;
  logic rst = 1;
  logic x0, y0, z0, p0, a0, n0;
  logic x1, y1, z1, p1, a1, n1;
  logic [7:0] x2, y2, z2, p2;
  logic a2, n2;
  logic [7:0] x3, y3, z3, p3;
  logic a3, n3;
  logic [7:0] r0, r1, r2;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .PIPE(0)) u0 (.clk(clk), .rst(rst), .x(x0), .y(y0), .z(z0), .p(p0), .p_all(a0), .p_any(n0));
  and_gate #(.WIDTH(1), .PIPE(1)) u1 (.clk(clk), .rst(rst), .x(x1), .y(y1), .z(z1), .p(p1), .p_all(a1), .p_any(n1));
  and_gate #(.WIDTH(8), .PIPE(2)) u2 (.clk(clk), .rst(rst), .x(x2), .y(y2), .z(z2), .p(p2), .p_all(a2), .p_any(n2));
  and_gate #(.WIDTH(8), .PIPE(3)) u3 (.clk(clk), .rst(rst), .x(x3), .y(y3), .z(z3), .p(p3), .p_all(a3), .p_any(n3));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  initial begin
    {x0, y0, z0} = 3'b000;
    {x1, y1, z1} = 3'b111;
    x2 = 8'hFF; y2 = 8'hFF; z2 = 8'hFF;
    x3 = 8'hFF; y3 = 8'hFF; z3 = 8'hFF;
    #2;
    check("rst_p1", p1, 0);
    check("rst_all1", a1, 0);
    check("rst_any1", n1, 0);
    check("rst_p2", p2, 8'h00);
    check("rst_all2", a2, 0);
    check("rst_any2", n2, 0);
    check("rst_p3", p3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      {x0, y0, z0} = 3'(i);
      #10;
      check("comb_p", p0, (i == 7) ? 8'd1 : 8'd0);
      check("comb_all", a0, (i == 7) ? 8'd1 : 8'd0);
      check("comb_any", n0, (i == 7) ? 8'd1 : 8'd0);
    end
    @(negedge clk) rst = 0;
    {x1, y1, z1} = 3'b111;
    @(negedge clk) check("p1_111", p1, 1);
    check("p1_all", a1, 1);
    {x1, y1, z1} = 3'b011;
    @(negedge clk) check("p1_011", p1, 0);
    check("p1_any", n1, 0);
    {x1, y1, z1} = 3'b111;
    @(negedge clk) check("p1_hold", p1, 1);
    #2 rst = 1;
    #1 check("async_rst_p1", p1, 0);
    check("async_rst_p2", p2, 8'h00);
    @(negedge clk) rst = 0;
    #1 check("post_rel_p1", p1, 0);
    @(negedge clk) check("rel_p1", p1, 1);
    x2 = 8'hF0; y2 = 8'hFF; z2 = 8'h3C;
    @(negedge clk) check("p2_lat1", p2, 8'hFF);
    @(negedge clk) check("p2_30", p2, 8'h30);
    check("p2_any", n2, 1);
    check("p2_all", a2, 0);
    x2 = 8'hFF; y2 = 8'hFF; z2 = 8'hFF;
    @(negedge clk) check("p2_lat2", p2, 8'h30);
    @(negedge clk) check("p2_ff", p2, 8'hFF);
    check("p2_all_ff", a2, 1);
    r0 = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0 || i == 500) begin
        rst = 1;
        r0 = 0; r1 = 0; r2 = 0;
        #1;
      end else rst = 0;
      check("pipe3_p", p3, r2);
      check("pipe3_all", a3, {7'd0, &r2});
      check("pipe3_any", n3, {7'd0, |r2});
      x3 = 8'($urandom); y3 = 8'($urandom); z3 = 8'($urandom);
      if (i % 50 == 7) begin
        x3 = 8'hFF; y3 = 8'hFF; z3 = 8'hFF;
      end
      if (!rst) begin
        r2 = r1; r1 = r0; r0 = x3 & y3 & z3;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
